layer_calc_array: RTL and testbench

LAYER_CALC_ARRAY -- requirements
Module: layer_calc_array

---
 rtl/layer_calc_array.sv | 110 +++++++++++
 tb/tb_layer_calc_array.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/layer_calc_array.sv
// Column MAC array: LANES pixels times one shared weight, summed over DEPTH
// accepted beats, then scaled by FRAC, saturated to OUTW and optionally ReLU-clamped.
module layer_calc_array #(
  parameter int LANES = 10,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int ACCW  = 40,
  parameter int FRAC  = 8,
  parameter int OUTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES*DW-1:0]   pixels,
  input  logic [DW-1:0]         weight,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  relu_en,
  output logic [LANES*OUTW-1:0] column,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = 2 * DW;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [ACCW-1:0]  acc_q [LANES];
  logic signed [ACCW-1:0]  acc_d [LANES];
  logic [LANES*OUTW-1:0]   column_q, column_d;

  logic signed [ACCW-1:0]  sum_w  [LANES];
  logic [LANES*OUTW-1:0]   fmt_w;
  logic                    accept;
  logic                    last_beat;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign column    = column_q;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && ((state_q == IDLE) ? (DEPTH == 1) : (cnt_q == LAST_CNT));

  // Lane datapath: the IDLE beat starts from zero so stale sums never leak in.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    fmt_w = '0;
    for (int i = 0; i < LANES; i++) begin
      logic signed [DW-1:0]   pix_s;
      logic signed [PW-1:0]   prod;
      logic signed [ACCW-1:0] shifted;
      logic signed [ACCW-1:0] sat;
      pix_s    = signed'(pixels[i*DW +: DW]);
      prod     = PW'(pix_s) * PW'(signed'(weight));
      sum_w[i] = ((state_q == IDLE) ? '0 : acc_q[i]) + ACCW'(prod);
      shifted  = sum_w[i] >>> FRAC;
      if (shifted > SAT_MAX)      sat = SAT_MAX;
      else if (shifted < SAT_MIN) sat = SAT_MIN;
      else                        sat = shifted;
      if (relu_en && sat < 0)     sat = '0;
      fmt_w[i*OUTW +: OUTW] = sat[OUTW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    column_d = column_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = sum_w;
          if (last_beat) begin
            cnt_d    = '0;
            column_d = fmt_w;
            state_d  = DONE;
          end else begin
            cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      column_q <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      column_q <= column_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_layer_calc_array.sv
// Directed self-checking bench for layer_calc_array at default parameters.
module tb_layer_calc_array;

  localparam int LANES = 10;
  localparam int DW    = 16;
  localparam int OUTW  = 16;
  localparam int COLW  = LANES * OUTW;
  localparam int PIXW  = LANES * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [PIXW-1:0] pixels;
  logic [DW-1:0]   weight;
  logic            in_valid;
  logic            in_ready;
  logic            relu_en;
  logic [COLW-1:0] column;
  logic            out_valid;
  logic            out_ready;

  int checks   = 0;
  int failures = 0;

  layer_calc_array dut (
    .clk       (clk),
    .reset     (reset),
    .pixels    (pixels),
    .weight    (weight),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .relu_en   (relu_en),
    .column    (column),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [COLW-1:0] obs, input logic [COLW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLW-1:0] rep_out(input logic [OUTW-1:0] v);
    logic [COLW-1:0] c;
    for (int i = 0; i < LANES; i++) c[i*OUTW +: OUTW] = v;
    return c;
  endfunction

  function automatic logic [PIXW-1:0] rep_pix(input logic [DW-1:0] v);
    logic [PIXW-1:0] p;
    for (int i = 0; i < LANES; i++) p[i*DW +: DW] = v;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [PIXW-1:0] p, input logic [DW-1:0] w, input logic relu);
    pixels   = p;
    weight   = w;
    relu_en  = relu;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    relu_en  = 1'b0;
  endtask

  // Four back-to-back beats; relu_last drives relu_en only on the final beat.
  task automatic window(input string tag, input logic [PIXW-1:0] p, input logic [DW-1:0] w,
                        input logic relu_last, input logic [COLW-1:0] exp_col);
    for (int b = 0; b < 3; b++) beat(p, w, 1'b0);
    check({tag, "_valid_before_last"}, COLW'(out_valid), COLW'(0));
    beat(p, w, relu_last);
    check({tag, "_out_valid"}, COLW'(out_valid), COLW'(1));
    check({tag, "_in_ready_done"}, COLW'(in_ready), COLW'(0));
    check({tag, "_column"}, column, exp_col);
  endtask

  task automatic drain(input string tag, input logic [COLW-1:0] exp_col);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, COLW'(out_valid), COLW'(0));
    check({tag, "_drain_ready"}, COLW'(in_ready), COLW'(1));
    check({tag, "_drain_column"}, column, exp_col);
  endtask

  initial begin
    logic [PIXW-1:0] ramp;
    logic [COLW-1:0] ramp_exp;

    reset     = 1'b1;
    pixels    = '0;
    weight    = '0;
    in_valid  = 1'b0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_column", column, '0);
    check("reset_out_valid", COLW'(out_valid), COLW'(0));
    check("reset_in_ready", COLW'(in_ready), COLW'(1));

    // 0x100*0x200*4 = 0x80000, >>8 = 0x800
    window("basic", rep_pix(16'h0100), 16'h0200, 1'b0, rep_out(16'h0800));
    drain("basic", rep_out(16'h0800));

    // 0x7FFF^2*4 >>8 far exceeds the positive limit
    window("sat_pos", rep_pix(16'h7FFF), 16'h7FFF, 1'b0, rep_out(16'h7FFF));
    drain("sat_pos", rep_out(16'h7FFF));
    window("sat_neg", rep_pix(16'h7FFF), 16'h8001, 1'b0, rep_out(16'h8000));
    drain("sat_neg", rep_out(16'h8000));
    window("relu", rep_pix(16'h7FFF), 16'h8001, 1'b1, rep_out(16'h0000));

    // Backpressure: beats offered in DONE must be ignored and the output held.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pixels   = rep_pix(16'h1234);
      weight   = 16'h4321;
      in_valid = 1'b1;
      tick();
      check("bp_out_valid", COLW'(out_valid), COLW'(1));
      check("bp_in_ready", COLW'(in_ready), COLW'(0));
      check("bp_column", column, rep_out(16'h0000));
    end
    in_valid = 1'b0;
    drain("bp", rep_out(16'h0000));
    window("after_bp", rep_pix(16'h0100), 16'h0200, 1'b0, rep_out(16'h0800));
    drain("after_bp", rep_out(16'h0800));

    // Reset mid-window discards the partial sums and clears the column.
    beat(rep_pix(16'h7FFF), 16'h7FFF, 1'b0);
    beat(rep_pix(16'h7FFF), 16'h7FFF, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_column", column, '0);
    check("midrst_out_valid", COLW'(out_valid), COLW'(0));
    window("midrst", rep_pix(16'h0100), 16'h0200, 1'b0, rep_out(16'h0800));
    drain("midrst", rep_out(16'h0800));

    // Bubbles: lane i pixel = i*0x100, gaps of 3 idle cycles between beats.
    for (int i = 0; i < LANES; i++) begin
      ramp[i*DW +: DW]       = DW'(i * 16'h0100);
      ramp_exp[i*OUTW +: OUTW] = OUTW'(i * 16'h0800);
    end
    for (int b = 0; b < 4; b++) begin
      beat(ramp, 16'h0200, 1'b0);
      if (b < 3) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          check("bubble_gap_valid", COLW'(out_valid), COLW'(0));
        end
      end
    end
    check("bubble_out_valid", COLW'(out_valid), COLW'(1));
    check("bubble_column", column, ramp_exp);
    drain("bubble", ramp_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
